pid_output_router: RTL and testbench
====================================

Name: pid_output_router

Overview:
- Parametrised successor to the fixed DAC/DDS output fan-out after the PID pipeline.
- Takes the PID output stream (dv/chan/data) and routes it to N_DAC DAC channels and N_DDS×3 DDS targets (freq/phase/amp).
- Holds a latest-value table per DAC channel, so bursts coalesce while the serial DAC controller is busy.
- Round-robin arbiter issues DAC writes under a dv/done handshake; per-channel route enables are host-writable.

Parameters:
- N_DAC, 8, number of DAC channels (pipeline chans 0..N_DAC-1).
- W_DAC_CHAN, 3, DAC channel index width, equal to clog2(N_DAC).
- N_DDS, 2, number of DDS devices; chans N_DAC+3k+{0,1,2} = freq/phase/amp of DDS k.
- W_CHAN, 5, pipeline channel width.
- W_DIN, 48, pipeline data width.
- W_DAC_DATA, 16, DAC word width, taken from the low bits of data_in.
- W_OVR, 16, width of the saturating coalesce counter.
- W_WR_ADDR / W_WR_CHAN / W_WR_DATA, 16/16/16, host write bus widths.
- ROUTE_EN_ADDR, 16'h0040, host address of the per-channel route enable.

Ports:
- clk_in  in  1  pid clock.
- rst_in  in  1  async active-high reset.
- dv_in  in  1  pipeline data valid.
- chan_in  in  W_CHAN  pipeline channel.
- data_in  in  W_DIN  pipeline data.
- wr_en  in  1  host write strobe.
- wr_addr  in  W_WR_ADDR  host write address.
- wr_chan  in  W_WR_CHAN  host target channel.
- wr_data  in  W_WR_DATA  host write data; bit0 is the enable.
- dac_dv_out  out  1  DAC write request pulse.
- dac_chan_out  out  W_DAC_CHAN  DAC channel.
- dac_data_out  out  W_DAC_DATA  DAC word.
- dac_done_in  in  1  DAC controller write-complete pulse.
- dds_freq_dv_out  out  N_DDS  per-DDS frequency strobe.
- dds_phase_dv_out  out  N_DDS  per-DDS phase strobe.
- dds_amp_dv_out  out  N_DDS  per-DDS amplitude strobe.
- dds_data_out  out  W_DIN  registered data for the DDS controllers (they slice it).
- ovr_count_out  out  W_OVR  saturating count of coalesced DAC writes.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is rst_in, asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - Pending bits 0, table 0.
  - Route enables all 1.
  - FSM in IDLE, round-robin pointer 0.
- Accept: dv_in with chan_in < N_DAC+3×N_DDS and enable[chan_in]=1. Otherwise the sample is dropped silently.
- DAC accept (chan < N_DAC):
  - table[chan] ← data_in[W_DAC_DATA-1:0]; pending[chan] ← 1.
  - If pending was already 1: overwrite with the newest value, and ovr_count increments, saturating at all-ones.
- DDS accept: k=(chan-N_DAC)/3, sel=(chan-N_DAC)%3.
  - Next cycle: the matching strobe bit k is high for exactly 1 cycle, and dds_data_out = data_in.
  - Latency 1. Back-to-back accepts give back-to-back strobes.
  - dds_data_out holds its value between strobes.
- Arbiter FSM:
  - IDLE: if any pending, pick the first pending channel at or after the rr pointer, with wrap. Then:
    - drive dac_chan_out/dac_data_out from the table and pulse dac_dv_out for 1 cycle;
    - clear pending for that channel;
    - rr ← chan+1 mod N_DAC;
    - go to WAIT.
  - WAIT: hold dac_chan/data stable; on dac_done_in go to IDLE.
  - The earliest next issue is the cycle after done, so the minimum spacing is 2 cycles plus the controller time.
- dac_done_in in IDLE is ignored.
- Simultaneous events:
  - If an accept hits the channel being issued in the same cycle, the issue carries the old table value. The set wins over the clear: pending stays 1 with the new value, and ovr_count is not incremented.
- Host write: wr_en and wr_addr==ROUTE_EN_ADDR and wr_chan < N_DAC+3×N_DDS → enable[wr_chan] ← wr_data[0].
  - Disabling a DAC channel also clears its pending bit.
  - A write with an out-of-range wr_chan is ignored.
- A rst_in assertion during WAIT aborts to IDLE immediately. Pending bits are lost; the DAC controller is reset by the same sys_rst.

Decomposition:
- Shared package (parameters.vh): N_DAC, N_DDS, W_* widths, ROUTE_EN_ADDR, DDS sel encodings FREQ=0/PHASE=1/AMP=2, FSM state encodings.
- One natural sub-module: rr_arbiter (N-bit request vector plus pointer → one-hot grant and index, combinational with a registered pointer). The DDS decode stays inline.

Test Plan:
- DAC single write: reset, dv chan=3 data=0x1234 → dac_dv pulse with chan=3, data=0x1234 one cycle after the accept. Hold until done; no further issue.
- Coalesce:
  - While in WAIT, write chan 5 values 0x0001, 0x0002, 0x0003 → after done, one issue chan 5 data 0x0003, and ovr_count=2.
  - Repeat with 0x10000+ overwrites → ovr_count saturates at 0xFFFF.
- Round robin: hold done high externally (1 cycle after each issue), mark chans 1, 6, 2 pending while rr=3 → issue order 6, 1, 2.
- DDS routing (N_DAC=8): dv chan=12 data=0xABCD_0000_1111 → next cycle dds_phase_dv_out=2'b10 and dds_data_out=0xABCD00001111. Chan 14 → no strobe (out of range), and the DAC side is idle.
- Enable mask: host write addr 0x40, chan 3, data 0 while chan 3 pending → pending cleared, no issue. A later dv on chan 3 is dropped. Re-enable, then dv on chan 3 → issued.
- Collision and reset: accept chan 0 in the same cycle it is issued → the issue carries the old value and a second issue carries the new value. Assert rst_in mid-WAIT → dac_dv 0, all pending 0, and ovr_count 0 asynchronously.

Source files
------------

// File: rtl/pid_output_router_pkg.sv
// rtl/pid_output_router_pkg.sv - shared widths, channel map and state encodings for the PID output router
package pid_output_router_pkg;

    localparam int N_DAC      = 8;
    localparam int W_DAC_CHAN = 3;
    localparam int N_DDS      = 2;
    localparam int W_CHAN     = 5;
    localparam int W_DIN      = 48;
    localparam int W_DAC_DATA = 16;
    localparam int W_OVR      = 16;
    localparam int W_WR_ADDR  = 16;
    localparam int W_WR_CHAN  = 16;
    localparam int W_WR_DATA  = 16;

    localparam logic [W_WR_ADDR-1:0] ROUTE_EN_ADDR = 16'h0040;

    // DAC channels first, then three consecutive targets per DDS device
    localparam int N_CHAN = N_DAC + 3 * N_DDS;

    typedef enum logic [1:0] {
        DDS_FREQ  = 2'd0,
        DDS_PHASE = 2'd1,
        DDS_AMP   = 2'd2
    } dds_sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/pid_output_router_rr_arbiter.sv
// rtl/pid_output_router_rr_arbiter.sv - round-robin pick of the first request at or after a registered pointer
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] ptr;

    always_comb begin
        int c;
        logic [W-1:0] ci;
        c     = 0;
        ci    = '0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            ci = W'(c);
            if (!any && req[ci]) begin
                any       = 1'b1;
                idx       = ci;
                grant[ci] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == W'(N - 1)) ? '0 : idx + W'(1);
        end
    end

endmodule

// File: rtl/pid_output_router.sv
// rtl/pid_output_router.sv - fans the PID output stream out to coalescing DAC writes and DDS strobes
module pid_output_router
    import pid_output_router_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  dv_in,
    input  logic [W_CHAN-1:0]     chan_in,
    input  logic [W_DIN-1:0]      data_in,
    input  logic                  wr_en,
    input  logic [W_WR_ADDR-1:0]  wr_addr,
    input  logic [W_WR_CHAN-1:0]  wr_chan,
    input  logic [W_WR_DATA-1:0]  wr_data,
    output logic                  dac_dv_out,
    output logic [W_DAC_CHAN-1:0] dac_chan_out,
    output logic [W_DAC_DATA-1:0] dac_data_out,
    input  logic                  dac_done_in,
    output logic [N_DDS-1:0]      dds_freq_dv_out,
    output logic [N_DDS-1:0]      dds_phase_dv_out,
    output logic [N_DDS-1:0]      dds_amp_dv_out,
    output logic [W_DIN-1:0]      dds_data_out,
    output logic [W_OVR-1:0]      ovr_count_out
);

    arb_state_t            state;
    logic [N_CHAN-1:0]     enable;
    logic [N_CHAN-1:0]     hit;
    logic [N_CHAN-1:0]     wr_sel;
    logic [N_DAC-1:0]      pending;
    logic [N_DAC-1:0]      grant;
    logic [W_DAC_DATA-1:0] dac_table [N_DAC];
    logic [W_DAC_CHAN-1:0] grant_idx;
    logic                  any_pending;
    logic                  issue;
    logic                  ovr_inc;
    logic [N_DDS-1:0]      freq_nxt;
    logic [N_DDS-1:0]      phase_nxt;
    logic [N_DDS-1:0]      amp_nxt;
    logic                  unused;

    assign unused = &{1'b0, wr_data[W_WR_DATA-1:1]};

    always_comb begin
        hit    = '0;
        wr_sel = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            hit[i]    = dv_in && (chan_in == W_CHAN'(i)) && enable[i];
            wr_sel[i] = wr_en && (wr_addr == ROUTE_EN_ADDR) && (wr_chan == W_WR_CHAN'(i));
        end
    end

    assign issue = (state == ST_IDLE) && any_pending;
    // A rewrite of the channel being issued this cycle is a fresh value, not a coalesce
    assign ovr_inc = |(hit[N_DAC-1:0] & pending & ~(issue ? grant : '0));

    always_comb begin
        freq_nxt  = '0;
        phase_nxt = '0;
        amp_nxt   = '0;
        for (int i = N_DAC; i < N_CHAN; i++) begin
            case (dds_sel_t'(2'((i - N_DAC) % 3)))
                DDS_FREQ:  freq_nxt[(i - N_DAC) / 3]  = hit[i];
                DDS_PHASE: phase_nxt[(i - N_DAC) / 3] = hit[i];
                default:   amp_nxt[(i - N_DAC) / 3]   = hit[i];
            endcase
        end
    end

    rr_arbiter #(.N(N_DAC), .W(W_DAC_CHAN)) u_arb (
        .clk     (clk_in),
        .rst     (rst_in),
        .req     (pending),
        .advance (issue),
        .grant   (grant),
        .idx     (grant_idx),
        .any     (any_pending)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending       <= '0;
            enable        <= '1;
            ovr_count_out <= '0;
            for (int i = 0; i < N_DAC; i++) dac_table[i] <= '0;
        end else begin
            for (int i = 0; i < N_DAC; i++) begin
                if (hit[i]) begin
                    dac_table[i] <= data_in[W_DAC_DATA-1:0];
                    pending[i]   <= 1'b1;
                end else if (issue && grant[i]) begin
                    pending[i] <= 1'b0;
                end
                if (wr_sel[i] && !wr_data[0]) pending[i] <= 1'b0;
            end
            for (int i = 0; i < N_CHAN; i++) begin
                if (wr_sel[i]) enable[i] <= wr_data[0];
            end
            if (ovr_inc && (ovr_count_out != '1)) ovr_count_out <= ovr_count_out + W_OVR'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= ST_IDLE;
            dac_dv_out   <= 1'b0;
            dac_chan_out <= '0;
            dac_data_out <= '0;
        end else begin
            dac_dv_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_pending) begin
                        dac_dv_out   <= 1'b1;
                        dac_chan_out <= grant_idx;
                        dac_data_out <= dac_table[grant_idx];
                        state        <= ST_WAIT;
                    end
                end
                default: begin
                    if (dac_done_in) state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dds_freq_dv_out  <= '0;
            dds_phase_dv_out <= '0;
            dds_amp_dv_out   <= '0;
            dds_data_out     <= '0;
        end else begin
            dds_freq_dv_out  <= freq_nxt;
            dds_phase_dv_out <= phase_nxt;
            dds_amp_dv_out   <= amp_nxt;
            if (|hit[N_CHAN-1:N_DAC]) dds_data_out <= data_in;
        end
    end

endmodule

// File: tb/tb_pid_output_router.sv
// tb/tb_pid_output_router.sv - directed self-checking bench for pid_output_router
module tb_pid_output_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [4:0]  chan;
    logic [47:0] data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_chan;
    logic [15:0] wr_data;
    logic        dac_dv;
    logic [2:0]  dac_chan;
    logic [15:0] dac_data;
    logic        done_req;
    logic        auto_done;
    logic        dac_done;
    logic [1:0]  freq_dv;
    logic [1:0]  phase_dv;
    logic [1:0]  amp_dv;
    logic [47:0] dds_data;
    logic [15:0] ovr;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0]  q_chan [$];
    logic [15:0] q_data [$];

    always #5 clk = ~clk;

    // Emulated DAC controller: manual done pulses, or done in the cycle right after each request
    assign dac_done = done_req | (auto_done & dac_dv);

    pid_output_router dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .dv_in            (dv),
        .chan_in          (chan),
        .data_in          (data),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_chan          (wr_chan),
        .wr_data          (wr_data),
        .dac_dv_out       (dac_dv),
        .dac_chan_out     (dac_chan),
        .dac_data_out     (dac_data),
        .dac_done_in      (dac_done),
        .dds_freq_dv_out  (freq_dv),
        .dds_phase_dv_out (phase_dv),
        .dds_amp_dv_out   (amp_dv),
        .dds_data_out     (dds_data),
        .ovr_count_out    (ovr)
    );

    always @(negedge clk) begin
        if (dac_dv) begin
            q_chan.push_back(dac_chan);
            q_data.push_back(dac_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pipe(input logic [4:0] c, input logic [47:0] d);
        dv = 1'b1; chan = c; data = d;
        tick();
        dv = 1'b0;
    endtask

    task automatic host(input logic [15:0] a, input logic [15:0] c, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic done_pulse();
        done_req = 1'b1;
        tick();
        done_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; chan = '0; data = '0;
        wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
        done_req = 1'b0; auto_done = 1'b0;
        idle(2);
        rst = 1'b0;
        tick();
        check("reset_dac_dv", dac_dv, 0);
        check("reset_dac_chan", dac_chan, 0);
        check("reset_dac_data", dac_data, 0);
        check("reset_ovr", ovr, 0);
        check("reset_dds_strobes", {freq_dv, phase_dv, amp_dv}, 0);
        check("reset_dds_data", dds_data, 0);

        // single DAC write
        pipe(5'd3, 48'h1234);
        tick();
        check("single_dv", dac_dv, 1);
        check("single_chan", dac_chan, 3);
        check("single_data", dac_data, 16'h1234);
        tick();
        check("single_dv_pulse", dac_dv, 0);
        check("single_chan_hold", dac_chan, 3);
        check("single_data_hold", dac_data, 16'h1234);
        idle(4);
        done_pulse();
        idle(5);
        check("single_issue_count", q_chan.size(), 1);

        // coalesce three writes while the controller is busy
        q_chan.delete(); q_data.delete();
        pipe(5'd0, 48'h00AA);
        tick();
        pipe(5'd5, 48'h1);
        pipe(5'd5, 48'h2);
        pipe(5'd5, 48'h3);
        check("coalesce_ovr", ovr, 2);
        done_pulse();
        idle(4);
        check("coalesce_count", q_chan.size(), 2);
        check("coalesce_chan", q_chan[1], 5);
        check("coalesce_data", q_data[1], 16'h0003);
        done_pulse();
        idle(2);

        // accept on the channel being issued in the same cycle
        dv = 1'b1; chan = 5'd0; data = 48'h0A0A;
        tick();
        data = 48'h0B0B;
        tick();
        dv = 1'b0;
        check("collide_first_dv", dac_dv, 1);
        check("collide_first_data", dac_data, 16'h0A0A);
        done_pulse();
        tick();
        check("collide_second_dv", dac_dv, 1);
        check("collide_second_chan", dac_chan, 0);
        check("collide_second_data", dac_data, 16'h0B0B);
        check("collide_ovr", ovr, 2);
        done_pulse();
        idle(2);

        // round robin from pointer 3 with pending 1, 6, 2
        q_chan.delete(); q_data.delete();
        pipe(5'd2, 48'h22);
        tick();
        pipe(5'd1, 48'h11);
        pipe(5'd6, 48'h66);
        pipe(5'd2, 48'h2222);
        auto_done = 1'b1;
        done_pulse();
        idle(12);
        auto_done = 1'b0;
        check("rr_count", q_chan.size(), 4);
        check("rr_first", q_chan[1], 6);
        check("rr_second", q_chan[2], 1);
        check("rr_third", q_chan[3], 2);
        check("rr_third_data", q_data[3], 16'h2222);
        check("rr_first_data", q_data[1], 16'h0066);

        // DDS routing
        q_chan.delete(); q_data.delete();
        pipe(5'd12, 48'hABCD_0000_1111);
        check("dds_phase_strobe", {freq_dv, phase_dv, amp_dv}, 6'b00_10_00);
        check("dds_data", dds_data, 48'hABCD_0000_1111);
        tick();
        check("dds_strobe_single", {freq_dv, phase_dv, amp_dv}, 0);
        check("dds_data_hold", dds_data, 48'hABCD_0000_1111);
        pipe(5'd14, 48'h5555);
        check("dds_oor_strobe", {freq_dv, phase_dv, amp_dv}, 0);
        check("dds_oor_data", dds_data, 48'hABCD_0000_1111);
        pipe(5'd8, 48'h8888);
        check("dds_b2b_freq", {freq_dv, phase_dv, amp_dv}, 6'b01_00_00);
        pipe(5'd13, 48'hD0D0);
        check("dds_b2b_amp", {freq_dv, phase_dv, amp_dv}, 6'b00_00_10);
        check("dds_b2b_data", dds_data, 48'hD0D0);
        idle(3);
        check("dds_no_dac", q_chan.size(), 0);

        // route enable mask
        pipe(5'd0, 48'h1);
        tick();
        pipe(5'd3, 48'h3333);
        host(16'h0040, 16'd3, 16'd0);
        done_pulse();
        idle(5);
        check("mask_clears_pending", q_chan.size(), 1);
        pipe(5'd3, 48'h4444);
        idle(4);
        check("mask_drops", q_chan.size(), 1);
        host(16'h0040, 16'd3, 16'd1);
        host(16'h0041, 16'd3, 16'd0);
        pipe(5'd3, 48'h5555);
        tick();
        check("unmask_dv", dac_dv, 1);
        check("unmask_chan", dac_chan, 3);
        check("unmask_data", dac_data, 16'h5555);
        done_pulse();
        idle(2);

        // saturating coalesce counter
        pipe(5'd0, 48'h7);
        tick();
        for (int i = 0; i < 65540; i++) begin
            dv = 1'b1; chan = 5'd5; data = 48'(i);
            tick();
        end
        dv = 1'b0;
        check("ovr_saturate", ovr, 16'hFFFF);

        // asynchronous reset while a request is outstanding
        done_pulse();
        dv = 1'b1; chan = 5'd6; data = 48'h6666;
        tick();
        dv = 1'b0;
        check("sat_issue_dv", dac_dv, 1);
        check("sat_issue_chan", dac_chan, 5);
        check("sat_issue_data", dac_data, 16'h0003);
        rst = 1'b1;
        #1;
        check("async_rst_dv", dac_dv, 0);
        check("async_rst_ovr", ovr, 0);
        check("async_rst_data", dac_data, 0);
        idle(2);
        rst = 1'b0;
        q_chan.delete(); q_data.delete();
        idle(6);
        check("rst_pending_lost", q_chan.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
